auto_corner_detector: RTL and testbench
=======================================

Name: auto_corner_detector

Overview:
Responder side of the auto-detection handshake issued by the top-level mode FSM. On a one-cycle `start` pulse it raster-scans the frame buffer through a registered-read port and classifies each pixel as marker (`pixel_data >= threshold`). It tracks the four extreme marker pixels as the quadrilateral corners, publishes them, and pulses `done` so the FSM can enter manual corner adjustment.

Parameters:
- WIDTH, 640, frame width in pixels
- HEIGHT, 480, frame height in pixels
- X_BITS, 10, column coordinate width
- Y_BITS, 9, row coordinate width
- PIXEL_BITS, 8, pixel intensity width
- ADDR_BITS, 19, frame buffer address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request from mode FSM; accepted only in IDLE
- threshold  in  PIXEL_BITS  marker intensity threshold; sampled at start acceptance
- pixel_addr  out  ADDR_BITS  frame buffer read address, y*WIDTH+x
- pixel_data  in  PIXEL_BITS  read data, valid exactly 1 cycle after pixel_addr
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  one-cycle completion pulse
- found  out  1  at least one marker pixel seen in last scan
- corner_x  out  4*X_BITS  packed {BL,BR,TR,TL}; TL in LSBs
- corner_y  out  4*Y_BITS  packed, same order

Behaviour:
- Reset (async, any state): state=IDLE; pixel_addr=0; busy=0; done=0; found=0; corner_x=0; corner_y=0. Reset mid-scan aborts with no done pulse.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - On start=1, latch threshold, clear working regs and x/y/address counters, go to SCAN.
  - start is ignored in every other state, including DONE.
- SCAN:
  - Each cycle, drive pixel_addr for (x,y). x increments, wraps at WIDTH-1 to 0 with y+1. Address is a running incrementer; no multiplier.
  - (x,y) is delayed 1 cycle alongside the read, so the compare uses the data's true coordinate.
  - After issuing (WIDTH-1,HEIGHT-1), go to FLUSH. FLUSH processes the final pixel, then goes to DONE.
- Corner scores, computed on the delayed coordinate, unsigned, width max(X_BITS,Y_BITS)+2:
  - TL minimises x+y.
  - TR maximises x+(HEIGHT-1-y).
  - BR maximises x+y.
  - BL maximises (WIDTH-1-x)+y.
- Ties: strict compare, so the first pixel in raster order wins.
- The first marker pixel initialises all four corners and sets working found.
- DONE:
  - Copy working regs to corner_x/corner_y/found; done=1 for exactly this cycle; next state IDLE.
  - Outputs are otherwise stable between scans.
- No marker found: found=0; corners = TL(0,0), TR(WIDTH-1,0), BR(WIDTH-1,HEIGHT-1), BL(0,HEIGHT-1).
- Latency: start accepted at cycle 0 → SCAN cycles 1..W*H → FLUSH at W*H+1 → done at W*H+2.
- pixel_addr holds its last value outside SCAN.

Optional Feature:
- Macro: AUTO_CORNER_SUBSAMPLE_EN.
- Defined:
  - Scan only even x and even y; x steps by 2, address steps by 2 in-row and by 2*WIDTH-… to the next even row start.
  - SCAN lasts ceil(W/2)*ceil(H/2) cycles; done at that count+2.
  - Reported corners are even coordinates.
- Undefined: full-resolution scan as above.
- Fallback corners and handshake are identical in both builds.

Test Plan:
- WIDTH=8, HEIGHT=6, all pixels 0, threshold=128, start pulse:
  - done exactly 50 cycles after acceptance; found=0.
  - corners TL(0,0) TR(7,0) BR(7,5) BL(0,5).
- Markers (value 200) at (2,1),(6,1),(6,4),(1,4), threshold 128:
  - corners TL(2,1) TR(6,1) BR(6,4) BL(1,4); found=1.
  - pixel_addr sequence 0..47 with no gaps.
- Single marker at (3,3):
  - all four corners (3,3); found=1.
  - Tie check: markers (1,2),(2,1) → TL=(2,1), first in raster order.
- Second start during SCAN and in the DONE cycle:
  - both ignored; exactly one done pulse; second scan runs only after a start in IDLE.
- rst_n low at cycle 20 of a scan:
  - busy/done/outputs zero immediately.
  - Post-reset fresh scan produces correct corners; no stray done.
- AUTO_CORNER_SUBSAMPLE_EN defined, same 8x6 all-zero frame:
  - done 14 cycles after acceptance.
  - addresses 0,2,4,6,16,18,…,38.

Source files
------------

// File: rtl/auto_corner_detector.sv
// Purpose : raster-scans the frame buffer and reports the four extreme marker pixels as quad corners.
// Latency : done pulses at W*H+2 cycles after start acceptance (subsampled build: ceil(W/2)*ceil(H/2)+2).
// Backpressure: none; the frame buffer read port must return data exactly one cycle after pixel_addr.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, threshold    one-cycle scan request (IDLE only); threshold latched on acceptance
//   pixel_addr          frame buffer read address (y*WIDTH+x), holds outside SCAN
//   pixel_data          read data, valid one cycle after pixel_addr
//   busy, done, found   scan in progress / one-cycle completion pulse / marker seen in last scan
//   corner_x, corner_y  packed {BL,BR,TR,TL}, TL in the LSBs
//
// Build option: define AUTO_CORNER_SUBSAMPLE_EN to scan only even columns and even rows.
module auto_corner_detector #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PIXEL_BITS-1:0]   threshold,
    output logic [ADDR_BITS-1:0]    pixel_addr,
    input  logic [PIXEL_BITS-1:0]   pixel_data,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [4*X_BITS-1:0]     corner_x,
    output logic [4*Y_BITS-1:0]     corner_y
);

    localparam int S_BITS = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef AUTO_CORNER_SUBSAMPLE_EN
    // Even columns/rows only; the row jump lands on the start of the next even row.
    localparam int X_STEP   = 2;
    localparam int X_LAST   = ((WIDTH - 1) / 2) * 2;
    localparam int Y_LAST   = ((HEIGHT - 1) / 2) * 2;
    localparam int ROW_STEP = 2 * WIDTH - X_LAST;
`else
    localparam int X_STEP   = 1;
    localparam int X_LAST   = WIDTH - 1;
    localparam int Y_LAST   = HEIGHT - 1;
    localparam int ROW_STEP = 1;
`endif

    localparam logic [X_BITS-1:0] X_ZERO   = '0;
    localparam logic [Y_BITS-1:0] Y_ZERO   = '0;
    localparam logic [X_BITS-1:0] X_MAXV   = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_MAXV   = Y_BITS'(HEIGHT - 1);
    localparam logic [X_BITS-1:0] X_LASTV  = X_BITS'(X_LAST);
    localparam logic [Y_BITS-1:0] Y_LASTV  = Y_BITS'(Y_LAST);

    // Corners reported when no marker is seen: {BL,BR,TR,TL}.
    localparam logic [3:0][X_BITS-1:0] FB_X = {X_ZERO, X_MAXV, X_MAXV, X_ZERO};
    localparam logic [3:0][Y_BITS-1:0] FB_Y = {Y_MAXV, Y_MAXV, Y_ZERO, Y_ZERO};

    logic [1:0]                 state;
    logic [PIXEL_BITS-1:0]      thr_q;
    logic [X_BITS-1:0]          x_cnt;
    logic [Y_BITS-1:0]          y_cnt;
    logic                       vld_d;
    logic [X_BITS-1:0]          x_d;
    logic [Y_BITS-1:0]          y_d;
    logic                       wfound;
    logic [3:0][X_BITS-1:0]     wx;
    logic [3:0][Y_BITS-1:0]     wy;

    logic                       hit;
    logic                       upd_found;
    logic [3:0][X_BITS-1:0]     upd_x;
    logic [3:0][Y_BITS-1:0]     upd_y;
    logic                       last_px;
    logic                       last_col;

    // Corner index: 0=TL (minimise), 1=TR, 2=BR, 3=BL (maximise).
    function automatic logic [S_BITS-1:0] score(input logic [1:0] k,
                                                input logic [X_BITS-1:0] x,
                                                input logic [Y_BITS-1:0] y);
        logic [S_BITS-1:0] sx;
        logic [S_BITS-1:0] sy;
        sx = S_BITS'(x);
        sy = S_BITS'(y);
        case (k)
            2'd0, 2'd2: score = sx + sy;
            2'd1:       score = sx + S_BITS'(HEIGHT - 1) - sy;
            default:    score = S_BITS'(WIDTH - 1) - sx + sy;
        endcase
    endfunction

    // Strict compare: an equal score never displaces the earlier raster pixel.
    function automatic logic better(input logic [1:0] k,
                                    input logic [X_BITS-1:0] xn, input logic [Y_BITS-1:0] yn,
                                    input logic [X_BITS-1:0] xo, input logic [Y_BITS-1:0] yo);
        if (k == 2'd0) better = score(k, xn, yn) < score(k, xo, yo);
        else           better = score(k, xn, yn) > score(k, xo, yo);
    endfunction

    assign hit      = vld_d && (pixel_data >= thr_q);
    assign last_col = (x_cnt == X_LASTV);
    assign last_px  = last_col && (y_cnt == Y_LASTV);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        upd_found = wfound;
        upd_x     = wx;
        upd_y     = wy;
        if (hit) begin
            upd_found = 1'b1;
            for (int k = 0; k < 4; k++) begin
                // First marker seeds every corner regardless of score.
                if (!wfound || better(2'(k), x_d, y_d, wx[k], wy[k])) begin
                    upd_x[k] = x_d;
                    upd_y[k] = y_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            thr_q      <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            pixel_addr <= '0;
            vld_d      <= 1'b0;
            x_d        <= '0;
            y_d        <= '0;
            wfound     <= 1'b0;
            wx         <= '0;
            wy         <= '0;
            found      <= 1'b0;
            corner_x   <= '0;
            corner_y   <= '0;
        end else begin
            // Coordinate travels alongside the registered read.
            vld_d <= (state == ST_SCAN);
            x_d   <= x_cnt;
            y_d   <= y_cnt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        thr_q      <= threshold;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                        pixel_addr <= '0;
                        wfound     <= 1'b0;
                        // Seeding with the fallback corners makes the no-marker result fall out naturally.
                        wx         <= FB_X;
                        wy         <= FB_Y;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    wfound <= upd_found;
                    wx     <= upd_x;
                    wy     <= upd_y;
                    if (last_px) begin
                        state <= ST_FLUSH;
                    end else if (last_col) begin
                        x_cnt      <= '0;
                        y_cnt      <= y_cnt + Y_BITS'(X_STEP);
                        pixel_addr <= pixel_addr + ADDR_BITS'(ROW_STEP);
                    end else begin
                        x_cnt      <= x_cnt + X_BITS'(X_STEP);
                        pixel_addr <= pixel_addr + ADDR_BITS'(X_STEP);
                    end
                end
                ST_FLUSH: begin
                    // Publish including the final pixel so results are valid alongside done.
                    wfound   <= upd_found;
                    wx       <= upd_x;
                    wy       <= upd_y;
                    found    <= upd_found;
                    corner_x <= upd_x;
                    corner_y <= upd_y;
                    state    <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auto_corner_detector.sv
module tb_auto_corner_detector;

    localparam int W = 8;
    localparam int H = 6;
`ifdef AUTO_CORNER_SUBSAMPLE_EN
    localparam int NSCAN     = 12;
    localparam int EXP_LAT   = 14;
    localparam int LAST_ADDR = 38;
`else
    localparam int NSCAN     = 48;
    localparam int EXP_LAT   = 50;
    localparam int LAST_ADDR = 47;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  threshold;
    logic [7:0]  pixel_addr;
    logic [7:0]  pixel_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [15:0] corner_x;
    logic [15:0] corner_y;

    auto_corner_detector #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(4), .Y_BITS(4), .PIXEL_BITS(8), .ADDR_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
        .pixel_addr(pixel_addr), .pixel_data(pixel_data), .busy(busy), .done(done),
        .found(found), .corner_x(corner_x), .corner_y(corner_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer with one-cycle registered read.
    logic [7:0] mem [W*H];
    always @(posedge clk) pixel_data <= (int'(pixel_addr) < W*H) ? mem[pixel_addr] : 8'd0;

    // Markers (mx,my,mv) and expected {BL,BR,TR,TL} nibbles for corner_x/corner_y.
    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][3:0]  mx;
        logic [3:0][3:0]  my;
        logic [3:0][7:0]  mv;
        logic [7:0]       thr;
        logic             ef;
        logic [15:0]      ecx;
        logic [15:0]      ecy;
    } vec_t;

    vec_t vt [6];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input int i);
`ifdef AUTO_CORNER_SUBSAMPLE_EN
        return (i / 4) * 16 + (i % 4) * 2;
`else
        return i;
`endif
    endfunction

    task automatic load_frame(input int vi);
        for (int i = 0; i < W*H; i++) mem[i] = 8'd0;
        for (int j = 0; j < int'(vt[vi].n); j++)
            mem[int'(vt[vi].my[j]) * W + int'(vt[vi].mx[j])] = vt[vi].mv[j];
    endtask

    // inj: also pulse start mid-SCAN and in the DONE cycle; post: idle cycles watched afterwards.
    task automatic run_scan(input int vi, input bit inj, input int post);
        int lat, done_lat, addr_err, extra_done, extra_busy;
        bit got, busy1, busy_done;
        logic [7:0] addr_at_done;
        load_frame(vi);
        @(negedge clk);
        threshold = vt[vi].thr;
        start = 1'b1;
        @(posedge clk);
        lat = 0; got = 0; addr_err = 0; done_lat = 0; busy1 = 0; busy_done = 0; addr_at_done = '0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) busy1 = busy;
            if (lat <= NSCAN && int'(pixel_addr) != exp_addr(lat - 1)) addr_err++;
            if (done) begin
                got = 1; done_lat = lat; busy_done = busy; addr_at_done = pixel_addr;
            end else if (inj && lat == 10) begin
                start = 1'b1;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
        check("done_latency", done_lat, EXP_LAT);
        check("busy_after_accept", busy1, 1);
        check("busy_in_done", busy_done, 1);
        check("addr_seq_errors", addr_err, 0);
        check("addr_hold", addr_at_done, LAST_ADDR);
        check("found", found, vt[vi].ef);
        check("corner_x", corner_x, vt[vi].ecx);
        check("corner_y", corner_y, vt[vi].ecy);
        if (inj) start = 1'b1;
        extra_done = 0; extra_busy = 0;
        for (int c = 0; c < post; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("extra_done", extra_done, 0);
        check("extra_busy", extra_busy, 0);
    endtask

    initial begin
        int nd;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; threshold = 8'd0;
        for (int i = 0; i < W*H; i++) mem[i] = 8'd0;

        for (int i = 0; i < 6; i++) vt[i] = '0;
        // 0: empty frame -> fallback corners
        vt[0].thr = 8'd128; vt[0].ef = 0; vt[0].ecx = 16'h0770; vt[0].ecy = 16'h5500;
        // 1: four markers at (2,1),(6,1),(6,4),(1,4)
        vt[1].n = 4; vt[1].mx = {4'd1, 4'd6, 4'd6, 4'd2}; vt[1].my = {4'd4, 4'd4, 4'd1, 4'd1};
        vt[1].mv = {4{8'd200}}; vt[1].thr = 8'd128; vt[1].ef = 1; vt[1].ecx = 16'h1662; vt[1].ecy = 16'h4411;
        // 2: single marker at (3,3)
        vt[2].n = 1; vt[2].mx[0] = 4'd3; vt[2].my[0] = 4'd3; vt[2].mv[0] = 8'd200;
        vt[2].thr = 8'd128; vt[2].ef = 1; vt[2].ecx = 16'h3333; vt[2].ecy = 16'h3333;
        // 3: tie (1,2) vs (2,1): TL/TR/BR=(2,1), BL=(1,2)
        vt[3].n = 2; vt[3].mx = {8'h0, 4'd2, 4'd1}; vt[3].my = {8'h0, 4'd1, 4'd2};
        vt[3].mv = {16'h0, 8'd200, 8'd200}; vt[3].thr = 8'd128; vt[3].ef = 1; vt[3].ecx = 16'h1222; vt[3].ecy = 16'h2111;
        // 4: pixel == threshold is a marker, one below is not
        vt[4].n = 2; vt[4].mx = {8'h0, 4'd0, 4'd4}; vt[4].my = {8'h0, 4'd0, 4'd2};
        vt[4].mv = {16'h0, 8'd99, 8'd100}; vt[4].thr = 8'd100; vt[4].ef = 1; vt[4].ecx = 16'h4444; vt[4].ecy = 16'h2222;
        // 5: markers (1,0),(7,1),(6,5),(0,4) near the frame edges
        vt[5].n = 4; vt[5].mx = {4'd0, 4'd6, 4'd7, 4'd1}; vt[5].my = {4'd4, 4'd5, 4'd1, 4'd0};
        vt[5].mv = {4{8'd255}}; vt[5].thr = 8'd1; vt[5].ef = 1; vt[5].ecx = 16'h0671; vt[5].ecy = 16'h4510;
`ifdef AUTO_CORNER_SUBSAMPLE_EN
        // Only even (x,y) markers are visible.
        vt[1].ecx = 16'h6666; vt[1].ecy = 16'h4444;
        vt[2].ef = 0; vt[2].ecx = 16'h0770; vt[2].ecy = 16'h5500;
        vt[3].ef = 0; vt[3].ecx = 16'h0770; vt[3].ecy = 16'h5500;
        vt[5].ecx = 16'h0000; vt[5].ecy = 16'h4444;
`endif

        repeat (3) @(negedge clk);
        check("reset_busy_done_found", {busy, done, found}, 3'b000);
        check("reset_corners", {corner_x, corner_y}, 32'h0);
        check("reset_addr", pixel_addr, 8'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) run_scan(v, 1'b0, 4);

        // Starts during SCAN and DONE are ignored; the next IDLE start runs a fresh scan.
        run_scan(1, 1'b1, 60);
        run_scan(2, 1'b0, 4);

        // Reset at cycle 20 of a scan aborts it with no done pulse.
        run_scan(1, 1'b0, 2);
        load_frame(1);
        @(negedge clk);
        threshold = 8'd128;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_busy_done_found", {busy, done, found}, 3'b000);
        check("midreset_corners", {corner_x, corner_y}, 32'h0);
        check("midreset_addr", pixel_addr, 8'h0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("midreset_stray_activity", nd, 0);
        run_scan(3, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
